// File: rtl/servo_pdm_decoder.sv
// Servo pulse decoder: measures the pulse high time and converts it back to an 8-bit duty code.
// Latency: valid/err strobe a few clocks after the input falling edge (2 sync + edge detect + output register).
// Backpressure: none; the consumer must take each one-cycle valid/err strobe as it occurs.
//
// Ports:
//   clk     - global clock
//   rst     - synchronous, active-high reset
//   en      - enable; low holds the decoder idle and drops any partial pulse
//   pdm_in  - asynchronous servo pulse input
//   duty    - last decoded duty value (holds across errors)
//   valid   - one-cycle strobe when duty is updated
//   err     - one-cycle strobe on a malformed or aborted pulse
//   lost    - level; no valid frame within LOST_CLKS
module servo_pdm_decoder #(
  parameter int clk_hz    = 25000000,
  parameter int PW_BASE   = 27501,
  parameter int PW_SHIFT  = 6,
  parameter int PW_GUARD  = 1250,
  parameter int PW_ABORT  = 75000,
  parameter int LOST_CLKS = clk_hz / 1000 * 40
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       pdm_in,
  output logic [7:0] duty,
  output logic       valid,
  output logic       err,
  output logic       lost
);

  localparam int CW    = $clog2(PW_ABORT + 1);
  localparam int LW    = $clog2(LOST_CLKS + 1);
  localparam int W_MIN = PW_BASE - PW_GUARD;
  localparam int W_MAX = PW_BASE + (255 << PW_SHIFT) + PW_GUARD;
  // Half an LSB, so the shift rounds to nearest instead of truncating.
  localparam int HALF  = 1 << (PW_SHIFT - 1);

  typedef enum logic [1:0] {IDLE, WAIT_RISE, MEASURE, WAIT_LOW} state_t;

  state_t          state;
  logic [CW-1:0]   cnt;
  logic [LW-1:0]   lcnt;

  // The synchroniser is deliberately left out of reset: it keeps tracking the
  // pin while rst is high, so a pulse already in progress at release is seen
  // as high and IDLE refuses to measure it.
  logic s_meta, s, s_d;
  always_ff @(posedge clk) begin
    s_meta <= pdm_in;
    s      <= s_meta;
    s_d    <= s;
  end

  logic rise, fall;
  assign rise = s & ~s_d;
  assign fall = ~s & s_d;

  // Classification of the measured width, used in the cycle the fall is seen.
  int         w_i;
  int         d_i;
  logic       in_range;
  logic [7:0] d_clamp;
  always_comb begin
    w_i      = int'(cnt);
    d_i      = (w_i - PW_BASE + HALF) >>> PW_SHIFT;
    in_range = (w_i >= W_MIN) && (w_i <= W_MAX);
    d_clamp  = 8'd0;
    if (d_i > 255)
      d_clamp = 8'd255;
    else if (d_i >= 0)
      d_clamp = d_i[7:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      lcnt  <= '0;
      duty  <= 8'd0;
      valid <= 1'b0;
      err   <= 1'b0;
      lost  <= 1'b1;
    end else if (!en) begin
      state <= IDLE;
      cnt   <= '0;
      lcnt  <= '0;
      valid <= 1'b0;
      err   <= 1'b0;
    end else begin
      valid <= 1'b0;
      err   <= 1'b0;

      // Frame watchdog: restarts on every rising edge, saturates at the limit.
      if (rise)
        lcnt <= '0;
      else if (lcnt != LW'(LOST_CLKS))
        lcnt <= lcnt + 1'b1;
      if (lcnt == LW'(LOST_CLKS))
        lost <= 1'b1;

      case (state)
        IDLE: begin
          if (!s) state <= WAIT_RISE;
        end
        WAIT_RISE: begin
          if (rise) begin
            cnt   <= CW'(1);
            state <= MEASURE;
          end
        end
        MEASURE: begin
          if (s) begin
            if (cnt == CW'(PW_ABORT)) begin
              err   <= 1'b1;
              state <= WAIT_LOW;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end else if (fall) begin
            state <= WAIT_RISE;
            if (in_range) begin
              duty  <= d_clamp;
              valid <= 1'b1;
              // Written after the watchdog so a good frame wins a same-cycle tie.
              lost  <= 1'b0;
            end else begin
              err <= 1'b1;
            end
          end else begin
            state <= WAIT_RISE;
          end
        end
        WAIT_LOW: begin
          if (!s) state <= WAIT_RISE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_servo_pdm_decoder.sv
// Bench for servo_pdm_decoder: directed and random pulses against a width-to-duty reference model.
// Runs with reduced timing parameters so every scenario fits in a short simulation.
// Strobes are matched in order against a queue of predicted events.
module tb_servo_pdm_decoder;

  localparam int CLK_HZ = 75000;             // gives LOST = 3000 clocks
  localparam int BASE   = 300;
  localparam int SH     = 2;
  localparam int GUARD  = 20;
  localparam int ABORT  = 1500;
  localparam int LOST   = CLK_HZ / 1000 * 40;

  logic       clk = 1'b0;
  logic       rst, en, pdm_in;
  logic [7:0] duty;
  logic       valid, err, lost;

  servo_pdm_decoder #(
    .clk_hz(CLK_HZ), .PW_BASE(BASE), .PW_SHIFT(SH),
    .PW_GUARD(GUARD), .PW_ABORT(ABORT)
  ) dut (
    .clk(clk), .rst(rst), .en(en), .pdm_in(pdm_in),
    .duty(duty), .valid(valid), .err(err), .lost(lost)
  );

  always #5 clk = ~clk;

  typedef struct {
    int kind;   // 1 = valid, 2 = err
    int d;
  } ev_t;

  ev_t exp_q[$];
  int  model_duty = 0;
  int  total = 0;
  int  bad   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", tag, got, want);
    end
  endtask

  // Reference: outcome of a pulse high for n clocks, from the encoding rules.
  function automatic void predict(input int n);
    ev_t e;
    int  v;
    if (n < BASE - GUARD || n > BASE + (255 << SH) + GUARD) begin
      e.kind = 2;
      e.d    = model_duty;
    end else begin
      v = n - BASE + (1 << (SH - 1));
      e.d = (v < 0) ? 0 : v / (1 << SH);
      if (e.d > 255) e.d = 255;
      e.kind = 1;
      model_duty = e.d;
    end
    exp_q.push_back(e);
  endfunction

  task automatic checkpoint(input string tag);
    check_eq({tag, "_pending"}, exp_q.size(), 0);
    check_eq({tag, "_duty"}, {24'd0, duty}, model_duty);
  endtask

  // Drive a pulse high for n clocks followed by gap low clocks (called at a negedge).
  task automatic pulse(input int n, input int gap, input string tag);
    predict(n);
    pdm_in = 1'b1;
    repeat (n) @(negedge clk);
    pdm_in = 1'b0;
    repeat (gap) @(negedge clk);
    if (gap >= 8) checkpoint(tag);
  endtask

  // Strobe monitor.
  always @(negedge clk) begin
    ev_t e;
    if (valid || err) begin
      check_eq("vld_err_excl", {31'd0, valid & err}, 0);
      if (exp_q.size() == 0) begin
        check_eq("unexpected_strobe", {30'd0, valid, err}, 0);
      end else begin
        e = exp_q.pop_front();
        check_eq("strobe_kind", valid ? 1 : 2, e.kind);
        if (valid) check_eq("strobe_duty", {24'd0, duty}, e.d);
      end
    end
  end

  initial begin
    int n, gap;
    rst = 1'b1; en = 1'b1; pdm_in = 1'b0;
    repeat (5) @(negedge clk);
    check_eq("rst_duty", {24'd0, duty}, 0);
    check_eq("rst_valid", {31'd0, valid}, 0);
    check_eq("rst_err", {31'd0, err}, 0);
    check_eq("rst_lost", {31'd0, lost}, 1);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    check_eq("lost_idle", {31'd0, lost}, 1);

    // Directed widths: zero, nominal, rounding, clamp, out of range, abort.
    pulse(300, 40, "d0");
    check_eq("lost_cleared", {31'd0, lost}, 0);
    pulse(1100, 30, "d200");
    pulse(1101, 30, "round_dn");
    pulse(1102, 30, "round_up");
    pulse(1335, 30, "clamp255");
    pulse(1345, 30, "too_long");
    pulse(200, 30, "too_short");
    pulse(1800, 30, "abort");
    pulse(1100, 30, "after_abort");

    // Back-to-back pulses separated by one low clock.
    pulse(700, 1, "b2b_a");
    pulse(900, 30, "b2b_b");

    // Random pulses across and beyond the valid range.
    for (int i = 0; i < 25; i++) begin
      n   = $urandom_range(260, 1420);
      gap = ($urandom_range(0, 3) == 0) ? 1 : $urandom_range(8, 60);
      pulse(n, gap, "rand");
    end
    repeat (20) @(negedge clk);
    checkpoint("rand_end");

    // en dropped and raised mid-pulse: that pulse is ignored.
    pdm_in = 1'b1;
    repeat (200) @(negedge clk);
    en = 1'b0;
    repeat (10) @(negedge clk);
    en = 1'b1;
    repeat (500) @(negedge clk);
    pdm_in = 1'b0;
    repeat (30) @(negedge clk);
    checkpoint("en_mid");
    pulse(700, 30, "after_en");

    // rst mid-pulse: outputs return to reset values, rest of pulse ignored.
    pdm_in = 1'b1;
    repeat (600) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_eq("midrst_duty", {24'd0, duty}, 0);
    check_eq("midrst_valid", {31'd0, valid}, 0);
    check_eq("midrst_err", {31'd0, err}, 0);
    check_eq("midrst_lost", {31'd0, lost}, 1);
    exp_q.delete();
    model_duty = 0;
    rst = 1'b0;
    repeat (500) @(negedge clk);
    pdm_in = 1'b0;
    repeat (30) @(negedge clk);
    checkpoint("midrst");
    pulse(700, 30, "after_rst");
    check_eq("lost_after_rst", {31'd0, lost}, 0);

    // Loss of signal around the boundary, err does not clear it, valid does.
    pulse(700, 0, "lost_seed");
    repeat (LOST - 700 - 30) @(negedge clk);
    check_eq("lost_before", {31'd0, lost}, 0);
    repeat (60) @(negedge clk);
    check_eq("lost_after", {31'd0, lost}, 1);
    checkpoint("lost_seed");
    pulse(200, 30, "lost_err");
    check_eq("lost_kept_by_err", {31'd0, lost}, 1);
    pulse(1100, 30, "lost_valid");
    check_eq("lost_cleared_valid", {31'd0, lost}, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
